// File: rtl/mc_pkg.sv
// Shared MC port definitions: command codes, request-entry layout, issue FSM states.
package mc_pkg;

    localparam logic [2:0] MC_CMD_RD     = 3'd1;
    localparam logic [2:0] MC_CMD_WR     = 3'd2;
    // Internal-only code for a queued flush; never accepted from the port.
    localparam logic [2:0] MC_CMD_FLUSH  = 3'd0;
    localparam logic [2:0] MC_RS_RD_DATA = 3'd2;
    localparam logic [2:0] MC_RS_WR_CMP  = 3'd3;
    localparam logic [1:0] MC_SIZE_8B    = 2'd3;

    // Word index straight from vadr[47:3]; reduced modulo the RAM depth at execute.
    localparam int MC_IDX_W = 45;

    // The rtnctl tag width is a per-instance parameter, so the tag travels
    // beside this struct in the FIFO word rather than inside it.
    typedef struct packed {
        logic [2:0]          cmd;
        logic [3:0]          scmd;
        logic [MC_IDX_W-1:0] index;
        logic [63:0]         data;
    } mc_rq_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } mc_fsm_e;

    function automatic logic mc_cmd_legal(input logic [2:0] cmd);
        return (cmd == MC_CMD_RD) || (cmd == MC_CMD_WR);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a second write port so two entries can land in one
// cycle (port 2 lands behind port 1). The writer must not push past full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr2_en,
    input  logic [WIDTH-1:0]       wr2_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr2;

    // Pointers carry one extra wrap bit, so full/empty fall out of the difference.
    assign wptr2   = wptr + PW'(wr_en);
    assign count   = wptr - rptr;
    assign full    = (count == PW'(DEPTH));
    assign empty   = (wptr == rptr);
    assign rd_data = mem[rptr[AW-1:0]];

    // Storage writes; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en)  mem[wptr[AW-1:0]]  <= wr_data;
        if (wr2_en) mem[wptr2[AW-1:0]] <= wr2_data;
    end

    // Pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + PW'(wr_en) + PW'(wr2_en);
            if (rd_en) rptr <= rptr + PW'(1);
        end
    end

endmodule

// File: rtl/mc_bram_responder.sv
// MC request/response terminator backed by on-chip block RAM. Requests and
// flushes queue in order; one entry is popped and executed per cycle, and the
// response beat is registered directly from the RAM read stage.
module mc_bram_responder
    import mc_pkg::*;
#(
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int RAM_DEPTH       = 18432,
    parameter int RQ_FIFO_DEPTH   = 16,
    parameter int STALL_SLACK     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mc_rq_vld,
    input  logic [2:0]                 mc_rq_cmd,
    input  logic [3:0]                 mc_rq_scmd,
    input  logic [47:0]                mc_rq_vadr,
    input  logic [1:0]                 mc_rq_size,
    input  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    input  logic [63:0]                mc_rq_data,
    input  logic                       mc_rq_flush,
    output logic                       mc_rq_stall,
    output logic                       mc_rs_vld,
    output logic [2:0]                 mc_rs_cmd,
    output logic [3:0]                 mc_rs_scmd,
    output logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    output logic [63:0]                mc_rs_data,
    input  logic                       mc_rs_stall,
    output logic                       err_overflow,
    output logic                       err_badsize
);

    localparam int CW = $clog2(RQ_FIFO_DEPTH) + 1;
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int EW = MC_RTNCTL_WIDTH + $bits(mc_rq_entry_t);

    logic                       rq_ok;
    logic                       push_rq;
    logic                       push_fl;
    logic                       pop;
    logic                       ovf_evt;
    logic [CW-1:0]              cnt;
    logic [CW-1:0]              free;
    logic [CW-1:0]              cnt_nxt;
    logic                       fifo_full;
    logic                       fifo_empty;
    mc_rq_entry_t               rq_ent;
    mc_rq_entry_t               fl_ent;
    mc_rq_entry_t               head;
    logic [MC_RTNCTL_WIDTH-1:0] head_tag;
    logic [EW-1:0]              fifo_rd;
    logic [AW-1:0]              ram_addr;
    logic [63:0]                ram [RAM_DEPTH];
    logic [63:0]                ram_q;
    logic                       rs_is_rd;
    mc_fsm_e                    state;
    logic                       unused_vadr_lo;

    // Byte offset within the word is meaningless for 8-byte accesses.
    assign unused_vadr_lo = ^mc_rq_vadr[2:0];

    // Accept: request lands first, a same-cycle flush needs a second free slot.
    assign rq_ok   = mc_rq_vld && mc_cmd_legal(mc_rq_cmd);
    assign free    = CW'(RQ_FIFO_DEPTH) - cnt;
    assign push_rq = rq_ok && !fifo_full;
    assign push_fl = mc_rq_flush && (free >= (rq_ok ? CW'(2) : CW'(1)));
    assign ovf_evt = (rq_ok && fifo_full) || (mc_rq_flush && !push_fl);
    assign pop     = (state == ST_ISSUE);
    assign cnt_nxt = cnt + CW'(push_rq) + CW'(push_fl) - CW'(pop);

    assign rq_ent = '{cmd: mc_rq_cmd, scmd: mc_rq_scmd, index: mc_rq_vadr[47:3], data: mc_rq_data};
    assign fl_ent = '{cmd: MC_CMD_FLUSH, scmd: 4'd0, index: '0, data: 64'd0};

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (RQ_FIFO_DEPTH)
    ) u_rq_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (push_rq),
        .wr_data  ({mc_rq_rtnctl, rq_ent}),
        .wr2_en   (push_fl),
        .wr2_data ({{MC_RTNCTL_WIDTH{1'b0}}, fl_ent}),
        .rd_en    (pop),
        .rd_data  (fifo_rd),
        .count    (cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign {head_tag, head} = fifo_rd;
    assign ram_addr = AW'(head.index % MC_IDX_W'(RAM_DEPTH));

    // Almost-full flag, taken from next-cycle occupancy so that when it is
    // seen high exactly STALL_SLACK slots are still open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mc_rq_stall <= 1'b0;
        else        mc_rq_stall <= (CW'(RQ_FIFO_DEPTH) - cnt_nxt) <= CW'(STALL_SLACK);
    end

    // Sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
            err_badsize  <= 1'b0;
        end else begin
            if (ovf_evt) err_overflow <= 1'b1;
            if (rq_ok && (mc_rq_size != MC_SIZE_8B)) err_badsize <= 1'b1;
        end
    end

    // RAM stage: one entry per edge, so a read always follows any earlier
    // write to the same word by at least one edge and sees the new data.
    always_ff @(posedge clk) begin
        if (pop) begin
            if (head.cmd == MC_CMD_WR) ram[ram_addr] <= head.data;
            ram_q <= ram[ram_addr];
        end
    end

    // Issue FSM and response registers. ISSUE repeats while work remains, so
    // the RESP beat of entry k overlaps the ISSUE of entry k+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            mc_rs_vld    <= 1'b0;
            mc_rs_cmd    <= 3'd0;
            mc_rs_scmd   <= 4'd0;
            mc_rs_rtnctl <= '0;
            rs_is_rd     <= 1'b0;
        end else begin
            mc_rs_vld <= pop;
            if (pop) begin
                mc_rs_cmd    <= (head.cmd == MC_CMD_RD) ? MC_RS_RD_DATA : MC_RS_WR_CMP;
                mc_rs_scmd   <= head.scmd;
                mc_rs_rtnctl <= head_tag;
                rs_is_rd     <= (head.cmd == MC_CMD_RD);
            end
            case (state)
                ST_ISSUE: state <= ((cnt > CW'(1)) && !mc_rs_stall) ? ST_ISSUE : ST_RESP;
                default:  state <= (!fifo_empty && !mc_rs_stall) ? ST_ISSUE : ST_IDLE;
            endcase
        end
    end

    // Write completions carry zero data.
    assign mc_rs_data = rs_is_rd ? ram_q : 64'd0;

endmodule

// File: tb/tb_mc_bram_responder.sv
// Directed bench for mc_bram_responder: latency, ordering, stall slack,
// overflow, flush, address aliasing, bad size and async reset.
module tb_mc_bram_responder;
    import mc_pkg::*;

    localparam int RAM_DEPTH = 18432;

    logic        clk;
    logic        rst_n;
    logic        mc_rq_vld;
    logic [2:0]  mc_rq_cmd;
    logic [3:0]  mc_rq_scmd;
    logic [47:0] mc_rq_vadr;
    logic [1:0]  mc_rq_size;
    logic [31:0] mc_rq_rtnctl;
    logic [63:0] mc_rq_data;
    logic        mc_rq_flush;
    logic        mc_rq_stall;
    logic        mc_rs_vld;
    logic [2:0]  mc_rs_cmd;
    logic [3:0]  mc_rs_scmd;
    logic [31:0] mc_rs_rtnctl;
    logic [63:0] mc_rs_data;
    logic        mc_rs_stall;
    logic        err_overflow;
    logic        err_badsize;

    mc_bram_responder #(
        .MC_RTNCTL_WIDTH (32),
        .RAM_DEPTH       (RAM_DEPTH),
        .RQ_FIFO_DEPTH   (16),
        .STALL_SLACK     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mc_rq_vld    (mc_rq_vld),
        .mc_rq_cmd    (mc_rq_cmd),
        .mc_rq_scmd   (mc_rq_scmd),
        .mc_rq_vadr   (mc_rq_vadr),
        .mc_rq_size   (mc_rq_size),
        .mc_rq_rtnctl (mc_rq_rtnctl),
        .mc_rq_data   (mc_rq_data),
        .mc_rq_flush  (mc_rq_flush),
        .mc_rq_stall  (mc_rq_stall),
        .mc_rs_vld    (mc_rs_vld),
        .mc_rs_cmd    (mc_rs_cmd),
        .mc_rs_scmd   (mc_rs_scmd),
        .mc_rs_rtnctl (mc_rs_rtnctl),
        .mc_rs_data   (mc_rs_data),
        .mc_rs_stall  (mc_rs_stall),
        .err_overflow (err_overflow),
        .err_badsize  (err_badsize)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [3:0]  scmd;
        logic [31:0] tag;
        logic [63:0] data;
        int          cyc;
    } rsp_t;

    rsp_t rsp_q[$];
    int   cyc = 0;
    int   acc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response capture on the falling edge.
    always @(negedge clk) begin
        if (mc_rs_vld)
            rsp_q.push_back('{cmd: mc_rs_cmd, scmd: mc_rs_scmd, tag: mc_rs_rtnctl, data: mc_rs_data, cyc: cyc});
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // One-cycle request beat; acc records the cycle number of the accepting edge.
    task automatic drive(input logic [2:0] cmd, input logic [3:0] scmd, input logic [47:0] vadr,
                         input logic [31:0] tag, input logic [63:0] data, input logic [1:0] size,
                         input logic flush);
        mc_rq_vld    = 1'b1;
        mc_rq_cmd    = cmd;
        mc_rq_scmd   = scmd;
        mc_rq_vadr   = vadr;
        mc_rq_rtnctl = tag;
        mc_rq_data   = data;
        mc_rq_size   = size;
        mc_rq_flush  = flush;
        tick();
        acc          = cyc;
        mc_rq_vld    = 1'b0;
        mc_rq_flush  = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input string tag);
        int k;
        k = 0;
        while (rsp_q.size() < n && k < 1000) begin
            tick();
            k++;
        end
        if (rsp_q.size() < n) chk(tag, 64'(rsp_q.size()), 64'(n));
    endtask

    initial begin
        int acc0;
        int acc1;
        int nacc;
        int bad;
        int gaps;
        int k;

        rst_n        = 1'b0;
        mc_rq_vld    = 1'b0;
        mc_rq_cmd    = 3'd0;
        mc_rq_scmd   = 4'd0;
        mc_rq_vadr   = 48'd0;
        mc_rq_size   = 2'd3;
        mc_rq_rtnctl = 32'd0;
        mc_rq_data   = 64'd0;
        mc_rq_flush  = 1'b0;
        mc_rs_stall  = 1'b0;
        idle(3);

        // Reset values
        chk("rst_rq_stall", 64'(mc_rq_stall), 64'd0);
        chk("rst_rs_vld",   64'(mc_rs_vld),   64'd0);
        chk("rst_rs_cmd",   64'(mc_rs_cmd),   64'd0);
        chk("rst_rs_scmd",  64'(mc_rs_scmd),  64'd0);
        chk("rst_rs_tag",   64'(mc_rs_rtnctl), 64'd0);
        chk("rst_rs_data",  mc_rs_data,       64'd0);
        chk("rst_err_ovf",  64'(err_overflow), 64'd0);
        chk("rst_err_bad",  64'(err_badsize),  64'd0);
        rst_n = 1'b1;
        idle(2);

        // Write then read at 0x40
        drive(MC_CMD_WR, 4'h3, 48'h40, 32'd5, 64'hDEADBEEF_00000001, 2'd3, 1'b0);
        acc0 = acc;
        drive(MC_CMD_RD, 4'h7, 48'h40, 32'd6, 64'd0, 2'd3, 1'b0);
        acc1 = acc;
        wait_rsp(2, "wr_rd_timeout");
        chk("wr_cmd",  64'(rsp_q[0].cmd),  64'd3);
        chk("wr_tag",  64'(rsp_q[0].tag),  64'd5);
        chk("wr_scmd", 64'(rsp_q[0].scmd), 64'h3);
        chk("wr_data", rsp_q[0].data,      64'd0);
        chk("wr_lat",  64'(rsp_q[0].cyc - acc0), 64'd2);
        chk("rd_cmd",  64'(rsp_q[1].cmd),  64'd2);
        chk("rd_tag",  64'(rsp_q[1].tag),  64'd6);
        chk("rd_scmd", 64'(rsp_q[1].scmd), 64'h7);
        chk("rd_data", rsp_q[1].data,      64'hDEADBEEF_00000001);
        chk("rd_lat",  64'(rsp_q[1].cyc - acc1), 64'd2);

        // 300 back-to-back reads
        idle(4);
        rsp_q.delete();
        acc0 = 0;
        for (int i = 0; i < 300; i++) begin
            drive(MC_CMD_RD, 4'h1, 48'(i * 8), 32'(1000 + i), 64'd0, 2'd3, 1'b0);
            if (i == 0) acc0 = acc;
        end
        wait_rsp(300, "burst_timeout");
        idle(3);
        chk("burst_count", 64'(rsp_q.size()), 64'd300);
        bad  = 0;
        gaps = 0;
        for (int i = 0; i < rsp_q.size(); i++) begin
            if (rsp_q[i].tag !== 32'(1000 + i) || rsp_q[i].cmd !== 3'd2) bad++;
            if (i > 0 && rsp_q[i].cyc != rsp_q[i-1].cyc + 1) gaps++;
        end
        chk("burst_order", 64'(bad), 64'd0);
        chk("burst_gaps", 64'(gaps), 64'd0);
        chk("burst_first_lat", 64'(rsp_q[0].cyc - acc0), 64'd2);

        // Stall slack: stall rises with 4 free, 4 more fit without loss
        idle(4);
        rsp_q.delete();
        mc_rs_stall = 1'b1;
        nacc = 0;
        for (int i = 0; i < 16; i++) begin
            drive(MC_CMD_RD, 4'h2, 48'h40, 32'(2000 + i), 64'd0, 2'd3, 1'b0);
            nacc++;
            if (mc_rq_stall) break;
        end
        chk("stall_rise_at", 64'(nacc), 64'd12);
        for (int i = nacc; i < 16; i++)
            drive(MC_CMD_RD, 4'h2, 48'h40, 32'(2000 + i), 64'd0, 2'd3, 1'b0);
        idle(3);
        chk("stall_high", 64'(mc_rq_stall), 64'd1);
        chk("stall_no_ovf", 64'(err_overflow), 64'd0);
        chk("stall_no_rsp", 64'(rsp_q.size()), 64'd0);
        mc_rs_stall = 1'b0;
        wait_rsp(16, "stall_drain_timeout");
        idle(4);
        chk("stall_count", 64'(rsp_q.size()), 64'd16);
        bad = 0;
        for (int i = 0; i < rsp_q.size(); i++)
            if (rsp_q[i].tag !== 32'(2000 + i) || rsp_q[i].data !== 64'hDEADBEEF_00000001) bad++;
        chk("stall_order", 64'(bad), 64'd0);
        chk("stall_fall", 64'(mc_rq_stall), 64'd0);

        // Overflow: 17 requests into a stalled 16-entry queue
        idle(2);
        rsp_q.delete();
        mc_rs_stall = 1'b1;
        for (int i = 0; i < 17; i++)
            drive(MC_CMD_RD, 4'h0, 48'h48, 32'(3000 + i), 64'd0, 2'd3, 1'b0);
        chk("ovf_set", 64'(err_overflow), 64'd1);
        mc_rs_stall = 1'b0;
        wait_rsp(16, "ovf_drain_timeout");
        idle(10);
        chk("ovf_count", 64'(rsp_q.size()), 64'd16);
        bad = 0;
        for (int i = 0; i < rsp_q.size(); i++)
            if (rsp_q[i].tag !== 32'(3000 + i)) bad++;
        chk("ovf_order", 64'(bad), 64'd0);
        chk("ovf_sticky", 64'(err_overflow), 64'd1);

        // Request plus flush in the same cycle
        rsp_q.delete();
        drive(MC_CMD_RD, 4'h5, 48'h40, 32'h77, 64'd0, 2'd3, 1'b1);
        wait_rsp(2, "flush_timeout");
        chk("flush_rd_tag",  64'(rsp_q[0].tag), 64'h77);
        chk("flush_rd_data", rsp_q[0].data, 64'hDEADBEEF_00000001);
        chk("flush_cmd",     64'(rsp_q[1].cmd), 64'd3);
        chk("flush_tag",     64'(rsp_q[1].tag), 64'd0);
        chk("flush_scmd",    64'(rsp_q[1].scmd), 64'd0);
        chk("flush_data",    rsp_q[1].data, 64'd0);

        // Aliasing past RAM_DEPTH and a bad-size write
        idle(3);
        rsp_q.delete();
        drive(MC_CMD_WR, 4'h0, 48'h10, 32'h50, 64'h1111_2222_3333_4444, 2'd3, 1'b0);
        drive(MC_CMD_RD, 4'h0, 48'((RAM_DEPTH + 2) * 8 + 5), 32'h51, 64'd0, 2'd3, 1'b0);
        idle(1);
        chk("badsz_clear", 64'(err_badsize), 64'd0);
        drive(MC_CMD_WR, 4'h0, 48'((RAM_DEPTH + 2) * 8), 32'h52, 64'h5555_6666_7777_8888, 2'd1, 1'b0);
        drive(MC_CMD_RD, 4'h0, 48'h10, 32'h53, 64'd0, 2'd3, 1'b0);
        wait_rsp(4, "alias_timeout");
        chk("alias_rd",     rsp_q[1].data, 64'h1111_2222_3333_4444);
        chk("badsz_cmp",    64'({rsp_q[2].cmd, rsp_q[2].tag}), 64'({3'd3, 32'h52}));
        chk("alias_wr_rd",  rsp_q[3].data, 64'h5555_6666_7777_8888);
        chk("badsz_set",    64'(err_badsize), 64'd1);

        // Async reset with requests queued and a beat on the port
        idle(2);
        mc_rs_stall = 1'b1;
        for (int i = 0; i < 5; i++)
            drive(MC_CMD_RD, 4'h0, 48'h40, 32'(4000 + i), 64'd0, 2'd3, 1'b0);
        mc_rs_stall = 1'b0;
        k = 0;
        while (!mc_rs_vld && k < 10) begin
            tick();
            k++;
        end
        chk("rst_pre_vld", 64'(mc_rs_vld), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_vld", 64'(mc_rs_vld), 64'd0);
        chk("rst_async_ovf", 64'(err_overflow), 64'd0);
        chk("rst_async_bad", 64'(err_badsize), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_q.delete();
        idle(12);
        chk("rst_no_stale", 64'(rsp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
